// File: rtl/ker_unpack.sv
// rtl/ker_unpack.sv - unpacks wide kernel words into STR_KER_WIDTH lanes, LSB lane first.
// One config write arms a transfer of N narrow words; done pulses after the last one.
module ker_unpack #(
  parameter int                  CFG_DWIDTH    = 32,
  parameter int                  CFG_AWIDTH    = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_ADDR    = 5'd12,
  parameter int                  IN_WIDTH      = 64,
  parameter int                  STR_KER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CFG_DWIDTH-1:0]    cfg_data,
  input  logic [CFG_AWIDTH-1:0]    cfg_addr,
  input  logic                     cfg_valid,
  input  logic [IN_WIDTH-1:0]      in_data,
  input  logic                     in_val,
  output logic                     in_rdy,
  output logic [STR_KER_WIDTH-1:0] str_ker,
  output logic                     str_ker_val,
  input  logic                     str_ker_rdy,
  output logic                     busy,
  output logic                     done
);

  localparam int R      = IN_WIDTH / STR_KER_WIDTH;
  localparam int LOG_R  = $clog2(R);
  localparam int LANE_W = (LOG_R > 0) ? LOG_R : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(R - 1);
  localparam logic [CFG_DWIDTH:0] R_M1      = (CFG_DWIDTH + 1)'(R - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CFG_DWIDTH-1:0]   out_left_q, out_left_d;
  logic [CFG_DWIDTH:0]     in_left_q, in_left_d;
  logic [IN_WIDTH-1:0]     hold_q, hold_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    full_q, full_d;
  logic                    done_q, done_d;

  logic                    cfg_hit;
  logic                    pop;
  logic                    last_lane;
  logic                    final_pop;
  logic                    accept;
  logic [CFG_DWIDTH:0]     n_round;
  logic [STR_KER_WIDTH-1:0] lane_sel;

  // One extra bit so N + R - 1 cannot wrap for the largest N.
  assign n_round   = {1'b0, cfg_data} + R_M1;
  assign cfg_hit   = cfg_valid && (cfg_addr == CFG_ADDR);
  assign pop       = full_q && str_ker_rdy;
  assign last_lane = (lane_q == LAST_LANE);
  assign final_pop = pop && (out_left_q == CFG_DWIDTH'(1));

  // Refill on the same edge the last lane leaves, so streaming has no bubble.
  assign in_rdy = (state_q == RUN) && (in_left_q != '0) &&
                  (!full_q || (pop && last_lane && (out_left_q > CFG_DWIDTH'(1))));
  assign accept = in_val && in_rdy;

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < R; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_sel = hold_q[i*STR_KER_WIDTH +: STR_KER_WIDTH];
      end
    end
  end

  assign str_ker     = full_q ? lane_sel : '0;
  assign str_ker_val = full_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;

  always_comb begin
    state_d    = state_q;
    out_left_d = out_left_q;
    in_left_d  = in_left_q;
    hold_d     = hold_q;
    lane_d     = lane_q;
    full_d     = full_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_hit) begin
          if (cfg_data != '0) begin
            state_d    = RUN;
            out_left_d = cfg_data;
            in_left_d  = n_round >> LOG_R;
            lane_d     = '0;
            full_d     = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pop) begin
          out_left_d = out_left_q - 1'b1;
          lane_d     = lane_q + 1'b1;
          // Lanes past the last needed one in a partial word are dropped here.
          if (last_lane || final_pop) begin
            full_d = 1'b0;
          end
          if (final_pop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        if (accept) begin
          hold_d    = in_data;
          lane_d    = '0;
          full_d    = 1'b1;
          in_left_d = in_left_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      out_left_q <= '0;
      in_left_q  <= '0;
      hold_q     <= '0;
      lane_q     <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_left_q <= out_left_d;
      in_left_q  <= in_left_d;
      hold_q     <= hold_d;
      lane_q     <= lane_d;
      full_q     <= full_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ker_unpack.sv
// tb/tb_ker_unpack.sv - directed cycle table plus backpressure and reset sequences for ker_unpack.
module tb_ker_unpack;

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h00FF_00EE_00DD_00CC;
  localparam logic [63:0] WA = 64'h000D_000C_000B_000A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic [63:0] in_data;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] str_ker;
  logic        str_ker_val;
  logic        str_ker_rdy;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  ker_unpack dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .str_ker(str_ker), .str_ker_val(str_ker_val), .str_ker_rdy(str_ker_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        iv;
    logic [63:0] id;
    logic        rdy;
    logic        e_in_rdy;
    logic        e_val;
    logic [15:0] e_ker;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                     input logic iv, input logic [63:0] id, input logic rdy,
                     input logic eir, input logic ev, input logic [15:0] ek,
                     input logic eb, input logic ed);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cd = cd; v.iv = iv; v.id = id; v.rdy = rdy;
    v.e_in_rdy = eir; v.e_val = ev; v.e_ker = ek; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic run_xfer(input string tag, input int n, input logic [63:0] w0,
                          input logic [63:0] w1, input int nw, input bit bp);
    logic [15:0] got[$];
    logic [15:0] held;
    int          widx;
    int          acc;
    int          cyc;
    bit          stall;
    bit          seen_done;
    widx = 0; acc = 0; cyc = 0; stall = 0; seen_done = 0; held = '0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = 5'd12; cfg_data = n;
    in_val = 1'b0; str_ker_rdy = 1'b1;
    while (!seen_done && cyc < 80) begin
      @(negedge clk);
      cfg_valid   = 1'b0;
      in_val      = (widx < nw);
      in_data     = (widx == 0) ? w0 : w1;
      str_ker_rdy = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (stall) chk({tag, " stall_hold"}, 64'(str_ker), 64'(held));
      if (str_ker_val && str_ker_rdy) got.push_back(str_ker);
      if (in_val && in_rdy) begin
        widx++;
        acc++;
      end
      stall = str_ker_val && !str_ker_rdy;
      held  = str_ker;
      if (done) seen_done = 1'b1;
      cyc++;
    end
    in_val = 1'b0;
    str_ker_rdy = 1'b1;
    chk({tag, " done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, " accepts"}, 64'(acc), 64'(nw));
    chk({tag, " out_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pops;
    int widx;
    int cyc;

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_val = 1'b0; in_data = '0; str_ker_rdy = 1'b1;
    #12;
    chk("reset in_rdy", 64'(in_rdy), 64'd0);
    chk("reset str_ker", 64'(str_ker), 64'd0);
    chk("reset str_ker_val", 64'(str_ker_val), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic N=8, two words back to back
    add(1, 12, 8, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    add(0, 0,  0, 1, W1, 1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd1, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd2, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd3, 1, 0);
    add(0, 0,  0, 1, W2, 1, 1, 1, 16'd4, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd5, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd6, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd7, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd8, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 0, 16'd0, 0, 1);
    add(0, 0,  0, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    // Partial final word N=6, third word offered and refused
    add(1, 12, 6, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    add(0, 0,  0, 1, W1, 1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd1, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd2, 1, 0);
    add(0, 0,  0, 1, W2, 1, 0, 1, 16'd3, 1, 0);
    add(0, 0,  0, 1, W2, 1, 1, 1, 16'd4, 1, 0);
    add(0, 0,  0, 1, W3, 1, 0, 1, 16'd5, 1, 0);
    add(0, 0,  0, 1, W3, 1, 0, 1, 16'd6, 1, 0);
    add(0, 0,  0, 1, W3, 1, 0, 0, 16'd0, 0, 1);
    add(0, 0,  0, 1, W3, 1, 0, 0, 16'd0, 0, 0);
    // Input gap between words
    add(1, 12, 8, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    add(0, 0,  0, 1, W1, 1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd1, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd2, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd3, 1, 0);
    add(0, 0,  0, 0, 0,  1, 1, 1, 16'd4, 1, 0);
    add(0, 0,  0, 0, 0,  1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 0, 0,  1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 1, W2, 1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd5, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd6, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd7, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 1, 16'd8, 1, 0);
    add(0, 0,  0, 0, 0,  1, 0, 0, 16'd0, 0, 1);
    add(0, 0,  0, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    // N=0 and wrong-address writes
    add(1, 12, 0, 0, 0,  1, 0, 0, 16'd0, 0, 0);
    add(0, 0,  0, 1, W1, 1, 0, 0, 16'd0, 0, 1);
    add(1, 3,  8, 1, W1, 1, 0, 0, 16'd0, 0, 0);
    add(0, 0,  0, 1, W1, 1, 0, 0, 16'd0, 0, 0);
    // N=4, then N=100 writes during RUN are ignored
    add(1, 12, 4,   0, 0,  1, 0, 0, 16'd0, 0, 0);
    add(1, 12, 100, 1, W1, 1, 1, 0, 16'd0, 1, 0);
    add(0, 0,  0,   1, W2, 1, 0, 1, 16'd1, 1, 0);
    add(0, 0,  0,   1, W2, 1, 0, 1, 16'd2, 1, 0);
    add(0, 0,  0,   1, W2, 1, 0, 1, 16'd3, 1, 0);
    add(1, 12, 100, 1, W2, 1, 0, 1, 16'd4, 1, 0);
    add(0, 0,  0,   1, W2, 1, 0, 0, 16'd0, 0, 1);
    add(0, 0,  0,   1, W2, 1, 0, 0, 16'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cfg_valid = vecs[i].cv; cfg_addr = vecs[i].ca; cfg_data = vecs[i].cd;
      in_val = vecs[i].iv; in_data = vecs[i].id; str_ker_rdy = vecs[i].rdy;
      #1;
      chk($sformatf("row%0d in_rdy", i), 64'(in_rdy), 64'(vecs[i].e_in_rdy));
      chk($sformatf("row%0d str_ker_val", i), 64'(str_ker_val), 64'(vecs[i].e_val));
      chk($sformatf("row%0d str_ker", i), 64'(str_ker), 64'(vecs[i].e_ker));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("row%0d done", i), 64'(done), 64'(vecs[i].e_done));
    end
    @(negedge clk);
    cfg_valid = 1'b0; in_val = 1'b0; str_ker_rdy = 1'b1;

    // Backpressure with ready pattern 1,0,0,1,0,0...
    exp_q = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    run_xfer("bp", 8, W1, W2, 2, 1'b1);

    // Reset after three of eight words
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = 5'd12; cfg_data = 32'd8;
    pops = 0; widx = 0; cyc = 0;
    while (pops < 3 && cyc < 40) begin
      @(negedge clk);
      cfg_valid   = 1'b0;
      in_val      = (widx < 2);
      in_data     = (widx == 0) ? W1 : W2;
      str_ker_rdy = 1'b1;
      #1;
      if (str_ker_val && str_ker_rdy) pops++;
      if (in_val && in_rdy) widx++;
      cyc++;
      @(posedge clk);
    end
    chk("rst pops_before", 64'(pops), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async str_ker", 64'(str_ker), 64'd0);
    chk("rst async str_ker_val", 64'(str_ker_val), 64'd0);
    chk("rst async busy", 64'(busy), 64'd0);
    chk("rst async in_rdy", 64'(in_rdy), 64'd0);
    chk("rst async done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d done", i), 64'(done), 64'd0);
      chk($sformatf("post_rst%0d busy", i), 64'(busy), 64'd0);
    end
    exp_q = {16'h000A, 16'h000B, 16'h000C, 16'h000D};
    run_xfer("after_rst", 4, WA, 64'd0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ker_unpack.md
# ker_unpack

Upstream feeder for the `kernel` weight buffer. It takes wide kernel words from the DMA/host input stream and unpacks each into `STR_KER_WIDTH`-bit lanes, least-significant first. It presents them on the `str_ker` / `str_ker_val` / `str_ker_rdy` stream that the kernel buffer writes into memory. Each transfer is armed by one config-bus write carrying the number of narrow words to emit. A `done` pulse marks completion.

## Interface
Parameters:
- `CFG_DWIDTH`, 32: config data width.
- `CFG_AWIDTH`, 5: config address width.
- `CFG_ADDR`, 5'd12: config address that arms a transfer.
- `IN_WIDTH`, 64: input stream word width.
- `STR_KER_WIDTH`, 16: output lane width. R = `IN_WIDTH`/`STR_KER_WIDTH` must be a power of two, ≥1.

Ports (one clock; `rst` is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `cfg_data`  in  `CFG_DWIDTH`  N = number of `STR_KER_WIDTH` words to emit.
- `cfg_addr`  in  `CFG_AWIDTH`  config address.
- `cfg_valid`  in  1  config write strobe.
- `in_data`  in  `IN_WIDTH`  packed input word; lane 0 = bits [`STR_KER_WIDTH`-1:0].
- `in_val`  in  1  input word valid.
- `in_rdy`  out  1  input word accepted when `in_val` & `in_rdy`.
- `str_ker`  out  `STR_KER_WIDTH`  unpacked kernel word.
- `str_ker_val`  out  1  `str_ker` valid.
- `str_ker_rdy`  in  1  downstream accepts when `str_ker_val` & `str_ker_rdy`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at transfer end.

## Operation
- **States:** IDLE, RUN.
- **IDLE → RUN:**
  - Trigger: `cfg_valid` & `cfg_addr`==`CFG_ADDR` & `cfg_data`!=0.
  - Load `out_left`=N.
  - Load `in_left`=ceil(N/R), i.e. (N+R-1)>>log2(R), computed at `CFG_DWIDTH`+1 bits so N=2^32-1 does not overflow.
- **N=0 in IDLE:** no state change; `done` pulses the next cycle.
- **Config writes during RUN:** ignored, any address equal to `CFG_ADDR` included.
- **Holding register:** one `IN_WIDTH` word plus a lane index (0..R-1) and a full flag.
- **Input accept rule (`in_rdy`, combinational):**
  - Requires RUN & `in_left`>0.
  - And either the register is empty, or the last lane is popping this cycle (lane==R-1 & `str_ker_val` & `str_ker_rdy`) and `out_left`>1 after… before the pop.
  - On accept: load the word, lane=0, full=1, `in_left`-=1.
- **Output:**
  - `str_ker` = lane[index] of the holding register, registered-path mux.
  - `str_ker_val` = full.
- **On each output transfer:**
  - `out_left`-=1 and lane+=1.
  - At lane R-1, or when `out_left` reaches 0, clear full unless refilled in the same cycle.
- **Partial final word:** when N mod R ≠ 0, lanes above the last needed one are discarded, never emitted.
- **RUN → IDLE:** on the transfer that makes `out_left`=0. Also clear full. `done`=1 on the following cycle only.
- **Extra input words:** never accepted; `in_rdy` is held 0 once `in_left`=0.

## Timing
- **Reset values:** `in_rdy`=0, `str_ker`=0, `str_ker_val`=0, `busy`=0, `done`=0. Internal counters, lane index and full flag all cleared.
- **Config to first accept:** config accepted at edge k; `busy` and `in_rdy` can be high from cycle k+1.
- **Input to output:** input accepted at edge k gives `str_ker_val`=1 and lane 0 on `str_ker` from cycle k+1.
- **Throughput:** one output word per cycle sustained with `in_val` and `str_ker_rdy` held high. The refill happens on the same edge as the last-lane pop, so there is no bubble.
- **Backpressure:** while `str_ker_val`=1 & `str_ker_rdy`=0, `str_ker` is held stable and no lane advances.
- **Completion:** `done` is high exactly one cycle, the cycle after the final transfer edge; `busy` falls on that same edge.
- **Reset mid-RUN:** immediate return to IDLE. The held word and remaining counts are lost, and no `done` is produced.
- **Simultaneous events:** an input accept and an output pop of a non-last lane cannot coincide, because the register is full. A config write coinciding with the final transfer is ignored, since the block is still in RUN at that edge.

## Test plan
1. **Basic 8-word transfer.** Config N=8 with R=4. Feed 64'h0004_0003_0002_0001 then 64'h0008_0007_0006_0005, `str_ker_rdy`=1. Expect:
   - `str_ker` = 1..8 on 8 consecutive cycles.
   - Exactly 2 input accepts.
   - `done` high one cycle after the 8th transfer; `busy` low from then.
2. **Partial final word.** Config N=6 with the same words, then a third word offered. Expect:
   - Output 1..6 only.
   - Lanes 7 and 8 dropped.
   - The third word is not accepted (`in_rdy`=0).
3. **Backpressure.** N=8, `str_ker_rdy` toggling 1,0,0,1,... Expect:
   - The same 1..8 sequence, with no duplicates or drops.
   - `str_ker` stable during every stall.
4. **Input gaps.** N=8, `in_val` low for 3 cycles between the two words. Expect `str_ker_val` low during the gap and the output sequence unchanged.
5. **Config edge cases.**
   - Config N=0: expect a `done` pulse next cycle, `in_rdy` never high.
   - Config N=4, then during RUN config N=100: the second write is ignored, and exactly 4 words are output.
6. **Reset mid-transfer.** Assert `rst` after 3 of 8 words. Expect:
   - All outputs 0 asynchronously, and no `done`.
   - A new config N=4 with word 64'h000D_000C_000B_000A outputs A,B,C,D.
